// File: rtl/mesh_term_src.sv
// mesh_term_src: show-ahead ingress FIFO for one mesh terminal port, with overflow reporting.
// Optional feature macro: TERM_OVF_CAPTURE_EN adds the ovf_data port (last dropped packet).
module mesh_term_src #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [pckg_sz-1:0]                data_in,
    output logic                              full,
    output logic [$clog2(fifo_depth):0]       count,
    output logic                              pndng_i_in,
    output logic [pckg_sz-1:0]                data_out_i_in,
    input  logic                              popin,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  drop_cnt
`ifdef TERM_OVF_CAPTURE_EN
    ,
    output logic [pckg_sz-1:0]                ovf_data
`endif
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
    localparam logic [PW-1:0] LAST_C  = PW'(fifo_depth - 1);

    // Handshake: pndng_i_in is the valid for the head packet, popin is the router's take strobe;
    // a pop happens only on a cycle with pndng_i_in=1 and popin=1. push has no ready: the producer
    // may watch full, and a push that cannot be accepted is dropped and counted.

    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;

    logic pop_ok;
    logic push_ok;
    logic drop;

    always_comb begin
        pop_ok  = popin && (count != '0);
        push_ok = push && ((count != DEPTH_C) || pop_ok);
        drop    = push && (count == DEPTH_C) && !popin;
    end

    assign pndng_i_in    = (count != '0);
    assign full          = (count == DEPTH_C);
    assign data_out_i_in = mem[rd_ptr];

    // Storage carries no reset: contents are never exposed while count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            overflow <= drop;
            if (drop && !(&drop_cnt)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

`ifdef TERM_OVF_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_data <= '0;
        end else if (drop) begin
            ovf_data <= data_in;
        end
    end
`else
    // Dropped payloads are discarded; only the drop pulse and counter record them.
`endif

endmodule

// File: tb/tb_mesh_term_src.sv
// Bench for mesh_term_src: queue-based reference model, directed corner cases and random traffic.
module tb_mesh_term_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        push_a, popin_a, push_b, popin_b;
  logic [39:0] data_a, data_b;
  logic        full_a, pndng_a, overflow_a, full_b, pndng_b, overflow_b;
  logic [2:0]  count_a, count_b;
  logic [39:0] head_a, head_b;
  logic [15:0] drop_a;
  logic [3:0]  drop_b;
`ifdef TERM_OVF_CAPTURE_EN
  logic [39:0] ovfd_a, ovfd_b;
`endif

  mesh_term_src #(.pckg_sz(40), .fifo_depth(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .push(push_a), .data_in(data_a), .full(full_a),
    .count(count_a), .pndng_i_in(pndng_a), .data_out_i_in(head_a), .popin(popin_a),
    .overflow(overflow_a), .drop_cnt(drop_a)
`ifdef TERM_OVF_CAPTURE_EN
    , .ovf_data(ovfd_a)
`endif
  );

  mesh_term_src #(.pckg_sz(40), .fifo_depth(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .push(push_b), .data_in(data_b), .full(full_b),
    .count(count_b), .pndng_i_in(pndng_b), .data_out_i_in(head_b), .popin(popin_b),
    .overflow(overflow_b), .drop_cnt(drop_b)
`ifdef TERM_OVF_CAPTURE_EN
    , .ovf_data(ovfd_b)
`endif
  );

  // reference model: plain queues, counters and last-drop registers
  logic [39:0] qa[$];
  logic [39:0] qb[$];
  int          dca, dcb;
  bit          ovfa, ovfb;
  logic [39:0] ovda, ovdb;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, fl, acc, drp;
    if (reset) begin
      qa.delete(); qb.delete();
      dca = 0; dcb = 0; ovfa = 0; ovfb = 0; ovda = '0; ovdb = '0;
    end else begin
      pop = popin_a && (qa.size() != 0);
      fl  = (qa.size() == 4);
      acc = push_a && (!fl || pop);
      drp = push_a && fl && !popin_a;
      if (pop) void'(qa.pop_front());
      if (acc) qa.push_back(data_a);
      ovfa = drp;
      if (drp) begin
        if (dca < 65535) dca++;
        ovda = data_a;
      end
      pop = popin_b && (qb.size() != 0);
      fl  = (qb.size() == 3);
      acc = push_b && (!fl || pop);
      drp = push_b && fl && !popin_b;
      if (pop) void'(qb.pop_front());
      if (acc) qb.push_back(data_b);
      ovfb = drp;
      if (drp) begin
        if (dcb < 15) dcb++;
        ovdb = data_b;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_a(input logic p, input logic [39:0] d, input logic pp);
    push_a = p; data_a = d; popin_a = pp;
  endtask

  task automatic set_b(input logic p, input logic [39:0] d, input logic pp);
    push_b = p; data_b = d; popin_b = pp;
  endtask

  // compare process: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_count", 64'(count_a), 64'(qa.size()));
      chk("a_full", 64'(full_a), 64'(qa.size() == 4));
      chk("a_pndng", 64'(pndng_a), 64'(qa.size() != 0));
      if (qa.size() != 0) chk("a_head", 64'(head_a), 64'(qa[0]));
      chk("a_overflow", 64'(overflow_a), 64'(ovfa));
      chk("a_drop_cnt", 64'(drop_a), 64'(dca));
      chk("b_count", 64'(count_b), 64'(qb.size()));
      chk("b_full", 64'(full_b), 64'(qb.size() == 3));
      chk("b_pndng", 64'(pndng_b), 64'(qb.size() != 0));
      if (qb.size() != 0) chk("b_head", 64'(head_b), 64'(qb[0]));
      chk("b_overflow", 64'(overflow_b), 64'(ovfb));
      chk("b_drop_cnt", 64'(drop_b), 64'(dcb));
`ifdef TERM_OVF_CAPTURE_EN
      chk("a_ovf_data", 64'(ovfd_a), 64'(ovda));
      chk("b_ovf_data", 64'(ovfd_b), 64'(ovdb));
`endif
    end
  end

  initial begin
    logic [63:0] rnd;
    int bias_push, bias_pop;
    reset = 1'b1;
    set_a(0, '0, 0);
    set_b(0, '0, 0);
    tick(); tick();
    chk_en = 1'b1;
    reset = 1'b0;
    tick();
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_pndng", 64'(pndng_a), 64'd0);
    chk("rst_drop", 64'(drop_a), 64'd0);

    // fill and drain in order
    for (int i = 1; i <= 4; i++) begin
      set_a(1, 40'(i), 0); tick();
    end
    set_a(0, '0, 0); tick();
    chk("t2_full", 64'(full_a), 64'd1);
    chk("t2_count", 64'(count_a), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", 64'(head_a), 64'(i));
      set_a(0, '0, 1); tick();
    end
    set_a(0, '0, 0);
    chk("t2_empty", 64'(pndng_a), 64'd0);

    // drop on full queue
    for (int i = 1; i <= 4; i++) begin
      set_a(1, 40'h10 + 40'(i), 0); tick();
    end
    set_a(1, 40'hAA, 0); tick();
    chk("t3_ovf", 64'(overflow_a), 64'd1);
    chk("t3_drop", 64'(drop_a), 64'd1);
    chk("t3_count", 64'(count_a), 64'd4);
    chk("t3_head", 64'(head_a), 64'h11);
    set_a(0, '0, 0); tick();
    chk("t3_ovf_pulse", 64'(overflow_a), 64'd0);
`ifdef TERM_OVF_CAPTURE_EN
    chk("t3_ovf_data", 64'(ovfd_a), 64'hAA);
`endif

    // simultaneous push and pop on full
    set_a(1, 40'hBB, 1); tick();
    chk("t4_ovf", 64'(overflow_a), 64'd0);
    chk("t4_count", 64'(count_a), 64'd4);
    chk("t4_head", 64'(head_a), 64'h12);
    set_a(0, '0, 1);
    repeat (3) tick();
    chk("t4_last", 64'(head_a), 64'hBB);
    tick();
    set_a(0, '0, 0);
    chk("t4_drained", 64'(count_a), 64'd0);

    // empty corners
    set_a(0, '0, 1); tick();
    chk("t5_pop_empty", 64'(count_a), 64'd0);
    set_a(1, 40'h5, 1); tick();
    chk("t5_count", 64'(count_a), 64'd1);
    chk("t5_head", 64'(head_a), 64'h5);
    set_a(0, '0, 1); tick();
    set_a(0, '0, 0);

    // reset mid-queue
    for (int i = 1; i <= 3; i++) begin
      set_a(1, 40'h20 + 40'(i), 0); tick();
    end
    set_a(0, '0, 0);
    chk("t1_pre", 64'(count_a), 64'd3);
    reset = 1'b1;
    tick(); tick();
    chk("t1_count", 64'(count_a), 64'd0);
    chk("t1_pndng", 64'(pndng_a), 64'd0);
    chk("t1_drop", 64'(drop_a), 64'd0);
    reset = 1'b0;
    tick();

    // saturating counter and pointer wrap on depth-3 instance
    for (int i = 0; i < 3; i++) begin
      set_b(1, 40'hB0 + 40'(i), 0); tick();
    end
    for (int i = 0; i < 20; i++) begin
      set_b(1, 40'hC0 + 40'(i), 0); tick();
    end
    set_b(0, '0, 0); tick();
    chk("t6_sat", 64'(drop_b), 64'hF);
    set_b(0, '0, 1);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      set_b(1, 40'hD0 + 40'(i), 0); tick();
    end
    for (int i = 0; i < 10; i++) begin
      set_b(1, 40'hE0 + 40'(i), 1); tick();
    end
    chk("t6_wrap_head", 64'(head_b), 64'hE8);
    set_b(0, '0, 1);
    repeat (3) tick();
    set_b(0, '0, 0);

    // random traffic with shifting bias
    bias_push = 50;
    bias_pop = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        bias_push = $urandom_range(10, 90);
        bias_pop = $urandom_range(10, 90);
      end
      reset = ($urandom_range(0, 299) == 0);
      rnd = {$urandom, $urandom};
      set_a($urandom_range(0, 99) < bias_push, rnd[39:0], $urandom_range(0, 99) < bias_pop);
      rnd = {$urandom, $urandom};
      set_b($urandom_range(0, 99) < bias_push, rnd[39:0], $urandom_range(0, 99) < bias_pop);
      tick();
    end
    reset = 1'b0;
    set_a(0, '0, 0);
    set_b(0, '0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
